// File: rtl/pll_dyncfg_pkg.sv
// Shared types and preset tables for the PLL dynamic-reconfiguration controller.
package pll_dyncfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRST  = 3'd1,
    WR    = 3'd2,
    RD    = 3'd3,
    CMP   = 3'd4,
    HOLD  = 3'd5,
    LOCKW = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_e;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int CFG_N_ENTRIES = 4;

  // Row index is the preset; entries are written in ascending order.
  localparam cfg_entry_t CFG_TABLE [2][CFG_N_ENTRIES] = '{
    '{ {6'h04, 8'h29}, {6'h05, 8'h02}, {6'h06, 8'h10}, {6'h07, 8'h01} },
    '{ {6'h04, 8'h13}, {6'h05, 8'h01}, {6'h06, 8'h08}, {6'h07, 8'h03} }
  };

endpackage

// File: rtl/pll_dyncfg_ctrl_rom.sv
// Combinational preset table lookup: (preset, entry index) -> {addr, data}.
module pll_cfg_rom
  import pll_dyncfg_pkg::*;
#(
  parameter int IDX_W = 2
) (
  input  logic             preset,
  input  logic [IDX_W-1:0] index,
  output logic [5:0]       addr,
  output logic [7:0]       data
);

  cfg_entry_t entry_s;

  // Table lookup
  always_comb begin
    entry_s = CFG_TABLE[preset][index];
  end

  assign addr = entry_s.addr;
  assign data = entry_s.data;

endmodule

// File: rtl/pll_dyncfg_ctrl.sv
// Writes a preset table into the PLL dynamic-config port, verifies each entry by
// readback, pulses the PLL reset and waits for lock. The PLL dclk is clk itself.
module pll_dyncfg_ctrl
  import pll_dyncfg_pkg::*;
#(
  parameter int N_ENTRIES    = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       preset,
  input  logic       pll_lock,
  input  logic [7:0] drdata,
  output logic [5:0] daddr,
  output logic [7:0] di,
  output logic       dcs,
  output logic       dwe,
  output logic       pll_reset,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int IDX_W   = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_ENTRIES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic             preset_r, preset_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  err_e             err_r, err_nxt_s;
  logic             done_r, done_nxt_s;
  logic [7:0]       exp_r;
  logic             lock_meta_r, lock_sync_r;
  logic [5:0]       rom_addr_s, daddr_r, daddr_nxt_s;
  logic [7:0]       rom_data_s, di_r, di_nxt_s;
  logic             dcs_r, dwe_r, pll_reset_r, busy_r;
  logic             dwe_nxt_s, pll_reset_nxt_s, busy_nxt_s, access_s;

  // The ROM is addressed with the next index so the dconfig outputs can be registered.
  pll_cfg_rom #(.IDX_W(IDX_W)) u_rom (
    .preset (preset_nxt_s),
    .index  (idx_nxt_s),
    .addr   (rom_addr_s),
    .data   (rom_data_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and sequencing decisions
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    preset_nxt_s = preset_r;
    cnt_nxt_s    = cnt_r;
    err_nxt_s    = err_r;
    done_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // done_r marks the cycle right after completion; a start there is dropped.
        if (start && !done_r) begin
          state_nxt_s  = PRST;
          preset_nxt_s = preset;
          err_nxt_s    = ERR_NONE;
          idx_nxt_s    = '0;
          cnt_nxt_s    = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRST: state_nxt_s = WR;
      WR:   state_nxt_s = RD;
      RD:   state_nxt_s = CMP;
      CMP: begin
        if (drdata != exp_r) begin
          err_nxt_s   = ERR_MISMATCH;
          state_nxt_s = IDLE;
        end else if (idx_r == IDX_LAST) begin
          cnt_nxt_s   = '0;
          state_nxt_s = HOLD;
        end else begin
          idx_nxt_s   = idx_r + IDX_W'(1);
          state_nxt_s = WR;
        end
      end
      HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          cnt_nxt_s   = '0;
          state_nxt_s = LOCKW;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      LOCKW: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (lock_sync_r) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = IDLE;
        end else if (cnt_r == LOCK_LAST) begin
          err_nxt_s   = ERR_TIMEOUT;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    access_s        = (state_nxt_s == WR) || (state_nxt_s == RD);
    dwe_nxt_s       = (state_nxt_s == WR);
    busy_nxt_s      = (state_nxt_s != IDLE);
    pll_reset_nxt_s = busy_nxt_s && (state_nxt_s != LOCKW);
    if (access_s) begin
      daddr_nxt_s = rom_addr_s;
      di_nxt_s    = rom_data_s;
    end else begin
      daddr_nxt_s = 6'h00;
      di_nxt_s    = 8'h00;
    end
  end

  // Datapath, synchronizer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r       <= '0;
      preset_r    <= 1'b0;
      cnt_r       <= '0;
      err_r       <= ERR_NONE;
      done_r      <= 1'b0;
      exp_r       <= 8'h00;
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
      daddr_r     <= 6'h00;
      di_r        <= 8'h00;
      dcs_r       <= 1'b0;
      dwe_r       <= 1'b0;
      pll_reset_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      idx_r       <= idx_nxt_s;
      preset_r    <= preset_nxt_s;
      cnt_r       <= cnt_nxt_s;
      err_r       <= err_nxt_s;
      done_r      <= done_nxt_s;
      exp_r       <= (state_nxt_s == WR) ? rom_data_s : exp_r;
      lock_meta_r <= pll_lock;
      lock_sync_r <= lock_meta_r;
      daddr_r     <= daddr_nxt_s;
      di_r        <= di_nxt_s;
      dcs_r       <= access_s;
      dwe_r       <= dwe_nxt_s;
      pll_reset_r <= pll_reset_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign daddr     = daddr_r;
  assign di        = di_r;
  assign dcs       = dcs_r;
  assign dwe       = dwe_r;
  assign pll_reset = pll_reset_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_pll_dyncfg_ctrl.sv
// Self-checking bench for pll_dyncfg_ctrl: table vectors, hand-written corner
// sequences and randomized runs against a cycle-budget reference model.
module tb_pll_dyncfg_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, preset, pll_lock;
  logic [7:0] drdata = 8'h00;
  logic [5:0] daddr;
  logic [7:0] di;
  logic       dcs, dwe, pll_reset, busy, done;
  logic [1:0] err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int N = 4;
  localparam int R = 16;
  localparam int T = 24000;

  logic [5:0] ref_addr [2][4] = '{'{6'h04, 6'h05, 6'h06, 6'h07}, '{6'h04, 6'h05, 6'h06, 6'h07}};
  logic [7:0] ref_data [2][4] = '{'{8'h29, 8'h02, 8'h10, 8'h01}, '{8'h13, 8'h01, 8'h08, 8'h03}};

  pll_dyncfg_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .preset(preset), .pll_lock(pll_lock),
    .drdata(drdata), .daddr(daddr), .di(di), .dcs(dcs), .dwe(dwe),
    .pll_reset(pll_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // PLL dynamic-config model: echoes writes, optionally corrupts one readback.
  logic [7:0]  mem [64];
  int          rd_cnt = 0;
  int          corrupt_idx = -1;
  logic [13:0] wr_log [$];

  always @(posedge clk) begin
    if (!pll_reset) rd_cnt <= 0;
    if (dcs && dwe) begin
      mem[daddr] <= di;
      wr_log.push_back({daddr, di});
    end
    if (dcs && !dwe) begin
      drdata <= (rd_cnt == corrupt_idx) ? (mem[daddr] ^ 8'hFF) : mem[daddr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_log(input bit p, input int n_exp);
    chk("wr_count", wr_log.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < wr_log.size()) begin
        chk($sformatf("wr%0d_addr", i), wr_log[i][13:8], ref_addr[p][i]);
        chk($sformatf("wr%0d_data", i), wr_log[i][7:0], ref_data[p][i]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_daddr"}, daddr, 0);
    chk({tag, "_di"}, di, 0);
    chk({tag, "_dcs"}, dcs, 0);
    chk({tag, "_dwe"}, dwe, 0);
    chk({tag, "_pll_reset"}, pll_reset, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Reference model: every entry costs 3 cycles, PRST 1, HOLD R, lock seen 2 cycles late.
  task automatic ref_model(input int corrupt, input int lock_dly,
                           output int e_end, output int e_done, output int e_err, output int e_wr);
    if (corrupt >= 0 && corrupt < N) begin
      e_wr = corrupt + 1; e_end = 1 + 3 * (corrupt + 1); e_done = 0; e_err = 1;
    end else if (lock_dly > 0 && lock_dly + 2 <= T) begin
      e_wr = N; e_end = 1 + 3 * N + R + lock_dly + 2; e_done = 1; e_err = 0;
    end else begin
      e_wr = N; e_end = 1 + 3 * N + R + T; e_done = 0; e_err = 2;
    end
  endtask

  // Runs one sequence. rel counts cycles after the edge that accepted start;
  // lock_dly is the number of cycles after pll_reset falls until lock is sampled.
  task automatic run_seq(input bit p, input int corrupt, input int lock_dly, input int extra_rel,
                         input bit start_at_done, input bit toggle_p,
                         output int end_rel, output int fall_rel, output int done_cnt,
                         output int done_rel, output int err_o);
    bit prev_rst;
    int rel;
    @(negedge clk);
    wr_log.delete();
    corrupt_idx = corrupt;
    pll_lock = 1'b0;
    preset = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (toggle_p) preset = ~p;
    chk("busy_after_start", busy, 1);
    chk("pll_reset_prst", pll_reset, 1);
    rel = 0; end_rel = -1; fall_rel = -1; done_cnt = 0; done_rel = -1; prev_rst = 1'b1;
    while (end_rel < 0) begin
      if (done) begin
        done_cnt++;
        done_rel = rel;
        if (start_at_done) begin start = 1'b1; preset = ~p; end
      end
      if (!busy) begin
        end_rel = rel;
      end else begin
        if (prev_rst && !pll_reset) fall_rel = rel;
        prev_rst = pll_reset;
        if (lock_dly > 0 && fall_rel >= 0 && rel - fall_rel == lock_dly - 1) pll_lock = 1'b1;
        if (rel == extra_rel) begin start = 1'b1; preset = ~p; end
        @(negedge clk);
        start = 1'b0;
        rel++;
        if (rel > 30000) begin
          n_tests++; n_fail++;
          $display("FAIL seq_timeout: busy still high after %0d cycles", rel);
          end_rel = rel;
        end
      end
    end
    err_o = err;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    bit p; int corrupt; int lock_dly;
    int exp_end; int exp_done; int exp_err; int exp_wr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int end_rel, fall_rel, dcnt, drel, e;
    int e_end, e_done, e_err, e_wr, busy_seen, rc, rl;
    bit rp;

    vecs[0] = '{1'b0, -1, 50, 81, 1, 0, 4};
    vecs[1] = '{1'b0,  2, 50, 10, 0, 1, 3};
    vecs[2] = '{1'b1, -1, 10, 41, 1, 0, 4};
    vecs[3] = '{1'b1,  0,  5,  4, 0, 1, 1};
    vecs[4] = '{1'b0,  3,  7, 13, 0, 1, 4};

    reset = 1'b1; start = 1'b0; preset = 1'b0; pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_seq(vecs[i].p, vecs[i].corrupt, vecs[i].lock_dly, -1, 1'b0, 1'b0,
              end_rel, fall_rel, dcnt, drel, e);
      chk($sformatf("v%0d_end", i), end_rel, vecs[i].exp_end);
      chk($sformatf("v%0d_done_cnt", i), dcnt, vecs[i].exp_done);
      chk($sformatf("v%0d_err", i), e, vecs[i].exp_err);
      chk($sformatf("v%0d_pll_reset_end", i), pll_reset, 0);
      check_log(vecs[i].p, vecs[i].exp_wr);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_err_hold", i), err, vecs[i].exp_err);
    end

    // Lock never arrives: timeout exactly T cycles after LOCKW entry.
    run_seq(1'b0, -1, -1, -1, 1'b0, 1'b0, end_rel, fall_rel, dcnt, drel, e);
    chk("to_lockw_entry", fall_rel, 29);
    chk("to_duration", end_rel - fall_rel, T);
    chk("to_err", e, 2);
    chk("to_done_cnt", dcnt, 0);

    // Lock seen in the very last LOCKW cycle beats the timeout.
    run_seq(1'b0, -1, T - 2, -1, 1'b0, 1'b0, end_rel, fall_rel, dcnt, drel, e);
    chk("edge_end", end_rel, 29 + T);
    chk("edge_done_cnt", dcnt, 1);
    chk("edge_err", e, 0);

    // Starts during HOLD and on the done pulse are ignored.
    run_seq(1'b0, -1, 50, 20, 1'b1, 1'b0, end_rel, fall_rel, dcnt, drel, e);
    chk("ign_end", end_rel, 81);
    chk("ign_done_rel", drel, 81);
    chk("ign_done_cnt", dcnt, 1);
    busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("ign_no_restart", busy_seen, 0);
    check_log(1'b0, 4);

    // Preset 1 selected, input toggled right after acceptance.
    run_seq(1'b1, -1, 10, -1, 1'b0, 1'b1, end_rel, fall_rel, dcnt, drel, e);
    chk("p1_end", end_rel, 41);
    chk("p1_err", e, 0);
    check_log(1'b1, 4);

    // Reset during WR of entry 1, then a full sequence.
    @(negedge clk);
    wr_log.delete(); corrupt_idx = -1; pll_lock = 1'b0; preset = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_wr_dcs", dcs, 1);
    chk("mr_wr_dwe", dwe, 1);
    chk("mr_wr_daddr", daddr, 6'h05);
    chk("mr_wr_di", di, 8'h02);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    run_seq(1'b0, -1, 50, -1, 1'b0, 1'b0, end_rel, fall_rel, dcnt, drel, e);
    chk("mr_end", end_rel, 81);
    chk("mr_done_cnt", dcnt, 1);
    chk("mr_err", e, 0);
    check_log(1'b0, 4);

    // Randomized runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      rp = 1'($urandom_range(0, 1));
      rc = int'($urandom_range(0, 6));
      if (rc >= N) rc = -1;
      rl = int'($urandom_range(1, 120));
      ref_model(rc, rl, e_end, e_done, e_err, e_wr);
      run_seq(rp, rc, rl, -1, 1'b0, 1'b0, end_rel, fall_rel, dcnt, drel, e);
      chk($sformatf("rnd%0d_end", r), end_rel, e_end);
      chk($sformatf("rnd%0d_done", r), dcnt, e_done);
      chk($sformatf("rnd%0d_err", r), e, e_err);
      check_log(rp, e_wr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_dyncfg_ctrl.md
PLL_DYNCFG_CTRL -- requirements
Module: pll_dyncfg_ctrl

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4: configuration entries per preset.
REQ-002 SHALL have parameter RST_CYCLES, default 16: clk cycles pll_reset is held high after programming.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 24000: clk cycles to wait for lock (1 ms at 24 MHz).
REQ-004 SHALL have port clk, input, 1: single clock; the top level also drives the PLL dclk from clk.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to reprogram; ignored unless busy=0.
REQ-007 SHALL have port preset, input, 1: preset select, sampled on the accepted start.
REQ-008 SHALL have port pll_lock, input, 1: asynchronous PLL lock flag.
REQ-009 SHALL have port drdata, input, 8: PLL dynamic-config read data, valid one cycle after a read strobe.
REQ-010 SHALL have port daddr, output, 6: dynamic-config address.
REQ-011 SHALL have port di, output, 8: dynamic-config write data.
REQ-012 SHALL have port dcs, output, 1: dynamic-config chip select.
REQ-013 SHALL have port dwe, output, 1: write enable, qualified by dcs.
REQ-014 SHALL have port pll_reset, output, 1: PLL reset request.
REQ-015 SHALL have port busy, output, 1: high while a sequence runs.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-017 SHALL have port err, output, 2: sticky error code: 0 none, 1 readback mismatch, 2 lock timeout.

Function
REQ-018 SHALL use FSM states IDLE, PRST, WR, RD, CMP, HOLD, LOCKW.
REQ-019 SHALL go IDLE->PRST on start with busy=0, latch preset, clear err, zero entry index, and drive busy=1 from the next cycle.
REQ-020 SHALL drive pll_reset=1 in PRST, WR, RD, CMP and HOLD; PRST lasts exactly 1 cycle, then WR.
REQ-021 SHALL, in WR, drive dcs=1, dwe=1, daddr/di = ROM entry[index] for exactly 1 cycle, then RD.
REQ-022 SHALL, in RD, drive dcs=1, dwe=0, same daddr for 1 cycle, then CMP.
REQ-023 SHALL, in CMP, compare drdata with the entry data: on mismatch set err=1 and go IDLE with busy=0 and pll_reset=0; on match with index=N_ENTRIES-1 go HOLD, otherwise increment index and return to WR.
REQ-024 SHALL drive dcs=0, dwe=0, daddr=0, di=0 in every state other than WR and RD.
REQ-025 SHALL stay in HOLD exactly RST_CYCLES cycles, then drop pll_reset and enter LOCKW with the timeout counter cleared.
REQ-026 SHALL pass pll_lock through a 2-flop synchronizer; LOCKW exits on synchronized lock=1 with a done pulse and to IDLE.
REQ-027 SHALL, if LOCKW reaches LOCK_TIMEOUT cycles without lock, set err=2 and go IDLE with no done pulse; a lock arriving in the same cycle as timeout wins (done, err=0).
REQ-028 SHALL give one sequence a latency of 1+3*N_ENTRIES+RST_CYCLES+L cycles from start to done, where L is the LOCKW duration.
REQ-029 SHALL ignore start while busy=1, including a start coincident with the done pulse.
REQ-030 SHALL, when IDLE, keep pll_reset=0 and busy=0; err holds its value until the next accepted start.

Reset
REQ-031 SHALL, on reset=1 in any state including mid-sequence, go to IDLE with daddr=0, di=0, dcs=0, dwe=0, pll_reset=0, busy=0, done=0, err=0, index=0, counters=0, and synchronizer flops=0.

Structure
REQ-032 SHALL place the FSM state enum, err codes, and the constant CFG_TABLE[2][N_ENTRIES] of {addr[5:0], data[7:0]} in package pll_dyncfg_pkg.
REQ-033 SHALL implement the preset table as sub-module pll_cfg_rom (inputs preset and index, combinational {addr, data} output) instantiated once.
REQ-034 SHALL set preset 0 entry 0 to {6'h04, 8'h29} and preset 1 entry 0 to {6'h04, 8'h13}.

Verification
REQ-035 SHALL show nominal operation: start, preset=0, PLL model echoes writes, lock rises 50 cycles after pll_reset falls -> first WR has daddr=6'h04 and di=8'h29, done pulses exactly 1+12+16+52 cycles after start, and err=0.
REQ-036 SHALL show readback mismatch: model corrupts entry 2 readback -> err=1, no done, busy and pll_reset low the cycle after CMP, and no WR to entry 3.
REQ-037 SHALL show lock timeout: pll_lock held 0 -> err=2 exactly 24000 cycles after LOCKW entry, and no done.
REQ-038 SHALL show mid-sequence reset: reset asserted during the WR of entry 1 -> all outputs are 0 on the next cycle, and a new start then runs a full sequence.
REQ-039 SHALL show start ignored while busy: start pulsed during HOLD and coincident with done -> exactly one sequence, and preset is unchanged.
REQ-040 SHALL show preset 1 selection: start with preset=1 -> first write is di=8'h13, and preset toggled after start has no effect.
